binoc_link_dir_ctrl: RTL and testbench

// - Direction controller for one bidirectional BiNoC inter-router channel; one instance sits at each end of the link.
// - Guarantees exactly one end drives the shared tri-state flit bus at any time.
// - Hands ownership over by a req/gnt exchange with the peer instance.
// - Hold counter bounds how long a busy owner can starve a requesting peer.
// - Router output arbitration uses tx_grant; the tri-state flit driver uses out_en.

---
 rtl/binoc_pkg.sv | 21 ++
 rtl/binoc_link_dir_ctrl.sv | 139 +++++++++++++
 tb/tb_binoc_link_dir_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/binoc_pkg.sv
// Shared definitions for the BiNoC bidirectional-link direction controller.
//
// link_dir_e   : per-end channel direction state
//   OWN  - this end drives the shared flit bus
//   REL  - one-cycle release: bus driver off, release pulse to the peer
//   IDLE - receiver, no pending ownership request
//   REQ  - receiver, ownership request held high toward the peer
// HOLD_DEFAULT : default number of flits an owner may still send once the
//                peer has asked for the channel
package binoc_pkg;

    typedef enum logic [1:0] {
        OWN  = 2'd0,
        REL  = 2'd1,
        IDLE = 2'd2,
        REQ  = 2'd3
    } link_dir_e;

    localparam int HOLD_DEFAULT = 8;

endpackage : binoc_pkg

// File: rtl/binoc_link_dir_ctrl.sv
// Direction controller for one end of a bidirectional BiNoC channel.
// Two instances (one HP, one LP) are cross-wired so that exactly one end
// drives the shared tri-state flit bus at any time.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous, active-low reset
//   local_req  in   this router has flits queued for the channel
//   tx_fire    in   a flit was placed on the bus this cycle
//   dir_req_i  in   peer asks for ownership (peer's dir_req_o)
//   dir_gnt_i  in   peer releases ownership (peer's dir_gnt_o)
//   dir_req_o  out  ownership request to the peer
//   dir_gnt_o  out  one-cycle release pulse to the peer
//   out_en     out  tri-state enable for this end's flit driver
//   tx_grant   out  router may send a flit this cycle
//   is_owner   out  this end owns the channel
//   proto_err  out  sticky protocol-violation flag
//   dbg_state  out  current FSM state, for observation only
//
// Ownership handshake: a receiver with traffic raises dir_req_o and keeps
// it high (even if its traffic disappears) until it samples dir_gnt_i=1.
// The owner answers a sampled request by entering REL for exactly one
// cycle: its driver is already off and dir_gnt_o pulses high. The
// requester samples that pulse and becomes owner on the following edge,
// so every handover has exactly one dead bus cycle and no overlap.
// A busy owner keeps the channel for at most MAX_HOLD flits after the
// request is seen; the flit that reaches the limit still counts.
module binoc_link_dir_ctrl
    import binoc_pkg::*;
#(
    parameter bit HP       = 1'b1,
    parameter int MAX_HOLD = HOLD_DEFAULT,
    parameter int CNT_W    = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      local_req,
    input  logic      tx_fire,
    input  logic      dir_req_i,
    input  logic      dir_gnt_i,
    output logic      dir_req_o,
    output logic      dir_gnt_o,
    output logic      out_en,
    output logic      tx_grant,
    output logic      is_owner,
    output logic      proto_err,
    output link_dir_e dbg_state
);

    localparam link_dir_e        RESET_STATE = HP ? OWN : IDLE;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT    = '1;

    link_dir_e        state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             proto_err_q, proto_err_d;
    logic             grant;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        proto_err_d = proto_err_q;
        grant       = (state_q == OWN) && local_req;

        // Violations are only recorded; they never steer the FSM.
        if (tx_fire && !grant) begin
            proto_err_d = 1'b1;
        end
        if (dir_gnt_i && (state_q != REQ)) begin
            proto_err_d = 1'b1;
        end
        if (dir_req_i && ((state_q == REQ) || (state_q == IDLE))) begin
            proto_err_d = 1'b1;
        end

        case (state_q)
            OWN: begin
                if (!dir_req_i) begin
                    hold_d = '0;
                end else if (!local_req) begin
                    state_d = REL;
                    hold_d  = '0;
                end else if (tx_fire) begin
                    // The limit flit is sent, then the channel is released.
                    if (hold_q == HOLD_LAST) begin
                        state_d = REL;
                        hold_d  = '0;
                    end else if (hold_q != HOLD_SAT) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            REL: begin
                state_d = IDLE;
                hold_d  = '0;
            end
            IDLE: begin
                hold_d = '0;
                if (local_req) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                hold_d = '0;
                if (dir_gnt_i) begin
                    state_d = OWN;
                end
            end
            default: begin
                state_d = RESET_STATE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RESET_STATE;
            hold_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Moore decode; tx_grant additionally qualifies ownership with demand.
    always_comb begin
        out_en    = (state_q == OWN);
        is_owner  = (state_q == OWN);
        tx_grant  = grant;
        dir_req_o = (state_q == REQ);
        dir_gnt_o = (state_q == REL);
        proto_err = proto_err_q;
        dbg_state = state_q;
    end

endmodule : binoc_link_dir_ctrl

// File: tb/tb_binoc_link_dir_ctrl.sv
// Bench for a cross-wired HP/LP pair of binoc_link_dir_ctrl.
// The reference model tracks the link as a whole: which end owns the bus
// (or that the bus is in its dead handover cycle), which ends have a
// visible request, and how many flits the owner has sent under pressure.
module tb_binoc_link_dir_ctrl;
    import binoc_pkg::*;

    localparam int MAX_HOLD = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- stimulus and DUT wiring ----------------
    logic hp_lr, lp_lr, hp_fire, lp_fire, inj_gnt_hp, inj_gnt_lp;
    logic hp_req_o, hp_gnt_o, hp_out_en, hp_tx_grant, hp_is_owner, hp_err;
    logic lp_req_o, lp_gnt_o, lp_out_en, lp_tx_grant, lp_is_owner, lp_err;
    logic hp_gnt_i, lp_gnt_i;
    link_dir_e hp_dbg, lp_dbg;

    assign hp_gnt_i = lp_gnt_o | inj_gnt_hp;
    assign lp_gnt_i = hp_gnt_o | inj_gnt_lp;

    binoc_link_dir_ctrl #(.HP(1'b1), .MAX_HOLD(MAX_HOLD), .CNT_W(4)) u_hp (
        .clk(clk), .rst(rst), .local_req(hp_lr), .tx_fire(hp_fire),
        .dir_req_i(lp_req_o), .dir_gnt_i(hp_gnt_i),
        .dir_req_o(hp_req_o), .dir_gnt_o(hp_gnt_o), .out_en(hp_out_en),
        .tx_grant(hp_tx_grant), .is_owner(hp_is_owner), .proto_err(hp_err),
        .dbg_state(hp_dbg)
    );

    binoc_link_dir_ctrl #(.HP(1'b0), .MAX_HOLD(MAX_HOLD), .CNT_W(4)) u_lp (
        .clk(clk), .rst(rst), .local_req(lp_lr), .tx_fire(lp_fire),
        .dir_req_i(hp_req_o), .dir_gnt_i(lp_gnt_i),
        .dir_req_o(lp_req_o), .dir_gnt_o(lp_gnt_o), .out_en(lp_out_en),
        .tx_grant(lp_tx_grant), .is_owner(lp_is_owner), .proto_err(lp_err),
        .dbg_state(lp_dbg)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int m_own;    // 0: HP end owns, 1: LP end owns, 2: dead handover cycle
    int m_rel;    // end releasing during the dead cycle
    int m_next;   // end taking over after the dead cycle
    int m_press;  // flits sent by the owner while the peer asks
    bit m_req [2];
    bit m_err [2];

    function automatic void model_reset();
        m_own   = 0;
        m_rel   = 0;
        m_next  = 0;
        m_press = 0;
        m_req[0] = 1'b0; m_req[1] = 1'b0;
        m_err[0] = 1'b0; m_err[1] = 1'b0;
    endfunction

    function automatic bit m_grant(int e);
        bit lr;
        lr = (e == 0) ? hp_lr : lp_lr;
        return (m_own == e) && lr;
    endfunction

    function automatic logic [11:0] exp_vec();
        logic [5:0] v [2];
        for (int e = 0; e < 2; e++) begin
            v[e] = {m_own == e, m_grant(e), m_own == e, m_req[e],
                    (m_own == 2) && (m_rel == e), m_err[e]};
        end
        return {v[0], v[1]};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {hp_out_en, hp_tx_grant, hp_is_owner, hp_req_o, hp_gnt_o, hp_err,
                lp_out_en, lp_tx_grant, lp_is_owner, lp_req_o, lp_gnt_o, lp_err};
    endfunction

    function automatic void model_step();
        bit lr [2];
        bit fr [2];
        bit gr [2];
        bit gi [2];
        bit rel;
        int o, p;
        lr[0] = hp_lr;   lr[1] = lp_lr;
        fr[0] = hp_fire; fr[1] = lp_fire;
        gr[0] = m_grant(0); gr[1] = m_grant(1);
        gi[0] = ((m_own == 2) && (m_rel == 1)) || inj_gnt_hp;
        gi[1] = ((m_own == 2) && (m_rel == 0)) || inj_gnt_lp;
        for (int e = 0; e < 2; e++) begin
            if (fr[e] && !gr[e]) m_err[e] = 1'b1;
            if (gi[e] && !m_req[e]) m_err[e] = 1'b1;
            if (m_req[1-e] && !((m_own == e) || ((m_own == 2) && (m_rel == e))))
                m_err[e] = 1'b1;
        end
        if (m_own == 2) begin
            m_req[m_next] = 1'b0;
            m_own = m_next;
        end else begin
            o = m_own;
            p = 1 - o;
            rel = 1'b0;
            if (m_req[p]) begin
                if (!lr[o]) begin
                    rel = 1'b1;
                end else if (fr[o]) begin
                    m_press++;
                    if (m_press >= MAX_HOLD) rel = 1'b1;
                end
            end else begin
                m_press = 0;
            end
            if (lr[p]) m_req[p] = 1'b1;
            if (rel) begin
                m_own = 2; m_rel = o; m_next = p; m_press = 0;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic hl, input logic ll, input logic hf, input logic lf);
        hp_lr = hl; lp_lr = ll; hp_fire = hf; lp_fire = lf;
        inj_gnt_hp = 1'b0; inj_gnt_lp = 1'b0;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();
        if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL reset_outputs got=%b exp=%b", obs_vec(), exp_vec());
        end
        n_cmp++;
        if (hp_dbg !== OWN || lp_dbg !== IDLE) begin
            n_err++; $display("FAIL reset_state got=%0d/%0d exp=%0d/%0d", hp_dbg, lp_dbg, OWN, IDLE);
        end
        n_cmp++;
        hp_lr = 1'b1; #1;
        if (hp_tx_grant !== 1'b1) begin
            n_err++; $display("FAIL reset_grant got=%b exp=1", hp_tx_grant);
        end
        n_cmp++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0);
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            n_cmp++;
            tick();
        end
        drive(0, 0, 0, 0);
        if (obs_vec() !== 12'b101000_000000) begin
            n_err++; $display("FAIL idle_quiet got=%b exp=%b", obs_vec(), 12'b101000_000000);
        end
        n_cmp++;
    endtask

    task automatic test_lp_request();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 0);
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL lp_req_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            n_cmp++;
            if (i == 1 && {lp_req_o, hp_out_en} !== 2'b11) begin
                n_err++; $display("FAIL lp_req_t1 got=%b exp=11", {lp_req_o, hp_out_en});
            end
            if (i == 2 && {hp_gnt_o, hp_out_en, lp_out_en} !== 3'b100) begin
                n_err++; $display("FAIL lp_req_t2 got=%b exp=100", {hp_gnt_o, hp_out_en, lp_out_en});
            end
            if (i == 3 && {lp_out_en, hp_out_en} !== 2'b10) begin
                n_err++; $display("FAIL lp_req_t3 got=%b exp=10", {lp_out_en, hp_out_en});
            end
            if (i >= 1 && i <= 3) n_cmp++;
            tick();
        end
    endtask

    task automatic test_hold_limit();
        int flits;
        flits = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(1, (i >= 3), 1, 0);
            hp_fire = m_grant(0);
            #1;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL hold_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            n_cmp++;
            if (hp_tx_grant && hp_fire && lp_req_o) flits++;
            tick();
        end
        drive(1, 1, 0, 0);
        if (flits !== MAX_HOLD) begin
            n_err++; $display("FAIL hold_flits got=%0d exp=%0d", flits, MAX_HOLD);
        end
        n_cmp++;
        if (lp_out_en !== 1'b1) begin
            n_err++; $display("FAIL hold_lp_owns got=%b exp=1", lp_out_en);
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int pressured;
        do_reset();
        pressured = 0;
        for (int i = 0; i < 200; i++) begin
            drive(1, 1, 0, 0);
            hp_fire = m_grant(0);
            lp_fire = m_grant(1);
            #1;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL b2b_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            n_cmp++;
            if (hp_out_en && lp_out_en) begin
                n_err++; $display("FAIL b2b_double_drive cyc=%0d got=11 exp=not11", i);
            end
            n_cmp++;
            if ((hp_tx_grant && hp_fire && lp_req_o) || (lp_tx_grant && lp_fire && hp_req_o))
                pressured++;
            if (!hp_tx_grant && !lp_tx_grant) pressured = 0;
            if (pressured > MAX_HOLD) begin
                n_err++; $display("FAIL b2b_tenure cyc=%0d got=%0d exp<=%0d", i, pressured, MAX_HOLD);
                pressured = 0;
            end
            n_cmp++;
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
            hp_fire = m_grant(0) && ($urandom_range(0, 3) != 0);
            lp_fire = m_grant(1) && ($urandom_range(0, 3) != 0);
            #1;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL rand_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            n_cmp++;
            tick();
        end
    endtask

    task automatic test_reset_mid_handover();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0);
            tick();
        end
        drive(0, 1, 0, 0);
        if ({hp_gnt_o, lp_req_o} !== 2'b11) begin
            n_err++; $display("FAIL midho_setup got=%b exp=11", {hp_gnt_o, lp_req_o});
        end
        n_cmp++;
        rst = 1'b0;
        model_reset();
        #1;
        if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL midho_reset got=%b exp=%b", obs_vec(), exp_vec());
        end
        n_cmp++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 0);
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL midho_resume cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            n_cmp++;
            tick();
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        drive(0, 0, 0, 0);
        inj_gnt_lp = 1'b1;
        #1;
        tick();
        drive(0, 0, 0, 0);
        if (lp_err !== 1'b1 || hp_err !== 1'b0) begin
            n_err++; $display("FAIL perr_gnt got=%b exp=10", {lp_err, hp_err});
        end
        n_cmp++;
        tick();
        drive(0, 0, 1, 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0);
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL perr_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            n_cmp++;
            tick();
        end
        if ({hp_err, lp_err} !== 2'b11) begin
            n_err++; $display("FAIL perr_sticky got=%b exp=11", {hp_err, lp_err});
        end
        n_cmp++;
        rst = 1'b0;
        #1;
        if ({hp_err, lp_err} !== 2'b00) begin
            n_err++; $display("FAIL perr_clear got=%b exp=00", {hp_err, lp_err});
        end
        n_cmp++;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0;
        hp_lr = 0; lp_lr = 0; hp_fire = 0; lp_fire = 0;
        inj_gnt_hp = 0; inj_gnt_lp = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_lp_request();
        test_hold_limit();
        test_back_to_back();
        test_random();
        test_reset_mid_handover();
        test_proto_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_binoc_link_dir_ctrl
